// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of one memory port between two clients, in-order response routing via a tag FIFO
module mem_arbiter #(
  parameter int TAG_DEPTH = 2,
  parameter int OP_WIDTH  = 68
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                c0_put_valid,
  output logic                c0_put_ready,
  input  logic [OP_WIDTH-1:0] c0_put_request,
  input  logic                c0_get_valid,
  output logic                c0_get_ready,
  output logic [OP_WIDTH-1:0] c0_get_response,
  input  logic                c1_put_valid,
  output logic                c1_put_ready,
  input  logic [OP_WIDTH-1:0] c1_put_request,
  input  logic                c1_get_valid,
  output logic                c1_get_ready,
  output logic [OP_WIDTH-1:0] c1_get_response,
  output logic                mem_put_valid,
  input  logic                mem_put_ready,
  output logic [OP_WIDTH-1:0] mem_put_request,
  output logic                mem_get_valid,
  input  logic                mem_get_ready,
  input  logic [OP_WIDTH-1:0] mem_get_response
);
  localparam int PW = TAG_DEPTH > 1 ? $clog2(TAG_DEPTH) : 1;
  localparam int CW = $clog2(TAG_DEPTH + 1);
  logic          tags [TAG_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          prio;
  logic          head, nonempty, pop, push, can_push, grant, both;
  // response routing: the oldest outstanding tag decides which client sees the memory response
  always_comb begin
    head            = tags[rd_ptr];
    nonempty        = count != '0;
    mem_get_valid   = RST_N && nonempty && (head ? c1_get_valid : c0_get_valid);
    pop             = mem_get_valid && mem_get_ready;
    c0_get_ready    = RST_N && nonempty && !head && mem_get_ready;
    c1_get_ready    = RST_N && nonempty && head && mem_get_ready;
    c0_get_response = mem_get_response;
    c1_get_response = mem_get_response;
  end
  // request arbitration: prio breaks ties, a lone requester always wins; a full FIFO admits only alongside a pop
  always_comb begin
    can_push        = (count < CW'(TAG_DEPTH)) || pop;
    both            = c0_put_valid && c1_put_valid;
    grant           = both ? prio : c1_put_valid;
    mem_put_valid   = RST_N && (c0_put_valid || c1_put_valid) && can_push;
    mem_put_request = grant ? c1_put_request : c0_put_request;
    c0_put_ready    = RST_N && mem_put_ready && can_push && (!c1_put_valid || !prio);
    c1_put_ready    = RST_N && mem_put_ready && can_push && (!c0_put_valid || prio);
    push            = mem_put_valid && mem_put_ready;
  end
  // tag FIFO and round-robin state; priority only flips when there was real contention
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      prio   <= 1'b0;
    end else begin
      if (push) begin
        tags[wr_ptr] <= grant;
        wr_ptr       <= (wr_ptr == PW'(TAG_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= (rd_ptr == PW'(TAG_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
      if (push && both) prio <= ~grant;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter against a small in-order memory model
module tb_mem_arbiter;
  logic        CLK = 1'b0;
  logic        RST_N;
  logic        c0_put_valid, c0_put_ready, c0_get_valid, c0_get_ready;
  logic        c1_put_valid, c1_put_ready, c1_get_valid, c1_get_ready;
  logic        mem_put_valid, mem_put_ready, mem_get_valid, mem_get_ready;
  logic [67:0] c0_put_request, c0_get_response, c1_put_request, c1_get_response;
  logic [67:0] mem_put_request, mem_get_response;
  logic [67:0] q [$];
  logic [31:0] mem [256];
  int          n_cmp = 0, n_mis = 0, rx0 = 0, rx1 = 0;
  logic [31:0] t2_addr [4] = '{32'h100, 32'h200, 32'h100, 32'h200};
  logic        t2_c0pr [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic        t2_g0r  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic        t2_g1r  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

  mem_arbiter #(.TAG_DEPTH(2), .OP_WIDTH(68)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .c0_put_valid(c0_put_valid), .c0_put_ready(c0_put_ready), .c0_put_request(c0_put_request),
    .c0_get_valid(c0_get_valid), .c0_get_ready(c0_get_ready), .c0_get_response(c0_get_response),
    .c1_put_valid(c1_put_valid), .c1_put_ready(c1_put_ready), .c1_put_request(c1_put_request),
    .c1_get_valid(c1_get_valid), .c1_get_ready(c1_get_ready), .c1_get_response(c1_get_response),
    .mem_put_valid(mem_put_valid), .mem_put_ready(mem_put_ready), .mem_put_request(mem_put_request),
    .mem_get_valid(mem_get_valid), .mem_get_ready(mem_get_ready), .mem_get_response(mem_get_response)
  );

  always #5 CLK = ~CLK;

  function automatic logic [67:0] op(logic [3:0] be, logic [31:0] a, logic [31:0] d);
    return {be, a, d};
  endfunction

  task automatic chk(string tag, logic [67:0] obs, logic [67:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chkb(string tag, logic obs, logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    logic pf, gf;
    logic [67:0] pr;
    logic [7:0] idx;
    #1;
    pf = mem_put_valid && mem_put_ready;
    gf = mem_get_valid && mem_get_ready;
    pr = mem_put_request;
    if (c0_get_valid && c0_get_ready) rx0++;
    if (c1_get_valid && c1_get_ready) rx1++;
    @(posedge CLK);
    #1;
    if (!RST_N) q.delete();
    else begin
      if (gf) void'(q.pop_front());
      if (pf) begin
        idx = pr[41:34];
        for (int b = 0; b < 4; b++) if (pr[64+b]) mem[idx][8*b +: 8] = pr[8*b +: 8];
        q.push_back({pr[67:32], (pr[67:64] != 4'h0) ? 32'h0 : mem[idx]});
      end
    end
    mem_get_ready    = q.size() != 0;
    mem_get_response = (q.size() != 0) ? q[0] : '0;
    @(negedge CLK);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    RST_N = 1'b0;
    c0_put_valid = 1'b1; c1_put_valid = 1'b1; c0_get_valid = 1'b1; c1_get_valid = 1'b1;
    c0_put_request = '0; c1_put_request = '0;
    mem_put_ready = 1'b1; mem_get_ready = 1'b0; mem_get_response = '0;
    @(negedge CLK);
    #1;
    chkb("rst_c0pr", c0_put_ready, 1'b0);
    chkb("rst_c1pr", c1_put_ready, 1'b0);
    chkb("rst_mpv", mem_put_valid, 1'b0);
    chkb("rst_mgv", mem_get_valid, 1'b0);
    cycle();
    cycle();
    // test 1: single read routed back to client 0
    RST_N = 1'b1; c1_put_valid = 1'b0; c1_get_valid = 1'b0;
    c0_put_request = op(4'h0, 32'h10, 32'h0);
    #1;
    chkb("t1_mpv", mem_put_valid, 1'b1);
    chk("t1_mpr", mem_put_request, op(4'h0, 32'h10, 32'h0));
    chkb("t1_c0pr", c0_put_ready, 1'b1);
    chkb("t1_c1gr_pre", c1_get_ready, 1'b0);
    cycle();
    c0_put_valid = 1'b0;
    #1;
    chkb("t1_c0gr", c0_get_ready, 1'b1);
    chk("t1_c0resp", c0_get_response, op(4'h0, 32'h10, 32'h0));
    chkb("t1_c1gr", c1_get_ready, 1'b0);
    cycle();
    #1;
    chkb("t1_c0gr_done", c0_get_ready, 1'b0);
    chkb("t1_mgv_done", mem_get_valid, 1'b0);
    // test 2: contention alternates grants, responses return to their owners
    rx0 = 0; rx1 = 0;
    c0_put_request = op(4'h0, 32'h100, 32'h0);
    c1_put_request = op(4'h0, 32'h200, 32'h0);
    c0_put_valid = 1'b1; c1_put_valid = 1'b1; c0_get_valid = 1'b1; c1_get_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("t2_addr%0d", i), {36'h0, mem_put_request[63:32]}, {36'h0, t2_addr[i]});
      chkb($sformatf("t2_c0pr%0d", i), c0_put_ready, t2_c0pr[i]);
      chkb($sformatf("t2_c1pr%0d", i), c1_put_ready, !t2_c0pr[i]);
      chkb($sformatf("t2_g0r%0d", i), c0_get_ready, t2_g0r[i]);
      chkb($sformatf("t2_g1r%0d", i), c1_get_ready, t2_g1r[i]);
      if (t2_g0r[i]) chk($sformatf("t2_r0_%0d", i), c0_get_response, op(4'h0, 32'h100, 32'h0));
      if (t2_g1r[i]) chk($sformatf("t2_r1_%0d", i), c1_get_response, op(4'h0, 32'h200, 32'h0));
      cycle();
    end
    c0_put_valid = 1'b0; c1_put_valid = 1'b0;
    #1;
    chkb("t2_g1r_last", c1_get_ready, 1'b1);
    chk("t2_r1_last", c1_get_response, op(4'h0, 32'h200, 32'h0));
    cycle();
    chk("t2_rx0", 68'(rx0), 68'd2);
    chk("t2_rx1", 68'(rx1), 68'd2);
    // test 3/4: client 0 stalls its response, client 1 queues behind, FIFO fills then push+pop together
    c0_get_valid = 1'b0; c1_get_valid = 1'b1;
    c0_put_valid = 1'b1; c0_put_request = op(4'h0, 32'h30, 32'h0);
    cycle();
    c0_put_valid = 1'b0;
    c1_put_valid = 1'b1; c1_put_request = op(4'h0, 32'h20, 32'h0);
    #1;
    chkb("t3_c1pr", c1_put_ready, 1'b1);
    chkb("t3_mpv", mem_put_valid, 1'b1);
    cycle();
    c1_put_valid = 1'b0;
    c0_put_valid = 1'b1; c0_put_request = op(4'h0, 32'h40, 32'h0);
    for (int i = 0; i < 5; i++) begin
      #1;
      chkb($sformatf("t3_c1gr%0d", i), c1_get_ready, 1'b0);
      chkb($sformatf("t3_c0gr%0d", i), c0_get_ready, 1'b1);
      chkb($sformatf("t3_mgv%0d", i), mem_get_valid, 1'b0);
      chkb($sformatf("t4_full_mpv%0d", i), mem_put_valid, 1'b0);
      chkb($sformatf("t4_full_c0pr%0d", i), c0_put_ready, 1'b0);
      cycle();
    end
    c0_get_valid = 1'b1;
    #1;
    chkb("t4_c0gr", c0_get_ready, 1'b1);
    chk("t4_c0resp", c0_get_response, op(4'h0, 32'h30, 32'h0));
    chkb("t4_mpv", mem_put_valid, 1'b1);
    chkb("t4_c0pr", c0_put_ready, 1'b1);
    chk("t4_mpr", mem_put_request, op(4'h0, 32'h40, 32'h0));
    cycle();
    c0_put_valid = 1'b0; c1_get_valid = 1'b0;
    c1_put_valid = 1'b1; c1_put_request = op(4'h0, 32'h70, 32'h0);
    #1;
    chkb("t4_still_full_mpv", mem_put_valid, 1'b0);
    chkb("t4_still_full_c1pr", c1_put_ready, 1'b0);
    c1_put_valid = 1'b0; c1_get_valid = 1'b1;
    #1;
    chkb("t3_c1gr", c1_get_ready, 1'b1);
    chk("t3_c1resp", c1_get_response, op(4'h0, 32'h20, 32'h0));
    cycle();
    #1;
    chkb("t4_c0gr_third", c0_get_ready, 1'b1);
    chk("t4_c0resp_third", c0_get_response, op(4'h0, 32'h40, 32'h0));
    chkb("t4_c1gr_third", c1_get_ready, 1'b0);
    cycle();
    #1;
    chkb("t4_empty_mgv", mem_get_valid, 1'b0);
    chkb("t4_empty_c0gr", c0_get_ready, 1'b0);
    // test 5: write then read the same word, data passes through unmodified
    c1_put_valid = 1'b1; c1_put_request = op(4'hF, 32'h8, 32'hDEADBEEF);
    cycle();
    c1_put_valid = 1'b0;
    c0_put_valid = 1'b1; c0_put_request = op(4'h0, 32'h8, 32'h0);
    #1;
    chkb("t5_c1gr", c1_get_ready, 1'b1);
    chk("t5_c1resp", c1_get_response, op(4'hF, 32'h8, 32'h0));
    chkb("t5_c0pr", c0_put_ready, 1'b1);
    cycle();
    c0_put_valid = 1'b0;
    #1;
    chkb("t5_c0gr", c0_get_ready, 1'b1);
    chk("t5_c0resp", c0_get_response, op(4'h0, 32'h8, 32'hDEADBEEF));
    cycle();
    // test 6: reset with two requests in flight discards them
    c0_get_valid = 1'b0; c1_get_valid = 1'b0;
    c0_put_valid = 1'b1; c0_put_request = op(4'h0, 32'h50, 32'h0);
    cycle();
    c0_put_valid = 1'b0;
    c1_put_valid = 1'b1; c1_put_request = op(4'h0, 32'h60, 32'h0);
    cycle();
    RST_N = 1'b0;
    c0_get_valid = 1'b1; c1_get_valid = 1'b1; c0_put_valid = 1'b1; c1_put_valid = 1'b1;
    #1;
    chkb("t6_c0gr", c0_get_ready, 1'b0);
    chkb("t6_c1gr", c1_get_ready, 1'b0);
    chkb("t6_c0pr", c0_put_ready, 1'b0);
    chkb("t6_c1pr", c1_put_ready, 1'b0);
    chkb("t6_mpv", mem_put_valid, 1'b0);
    chkb("t6_mgv", mem_get_valid, 1'b0);
    cycle();
    RST_N = 1'b1; c0_put_valid = 1'b0; c1_put_valid = 1'b0;
    rx0 = 0; rx1 = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chkb($sformatf("t6_post_c0gr%0d", i), c0_get_ready, 1'b0);
      chkb($sformatf("t6_post_c1gr%0d", i), c1_get_ready, 1'b0);
      chkb($sformatf("t6_post_mgv%0d", i), mem_get_valid, 1'b0);
      cycle();
    end
    chk("t6_rx", 68'(rx0 + rx1), 68'd0);
    c0_put_valid = 1'b1; c0_put_request = op(4'h0, 32'h80, 32'h0);
    c1_put_valid = 1'b1; c1_put_request = op(4'h0, 32'h90, 32'h0);
    #1;
    chkb("t6_new_mpv", mem_put_valid, 1'b1);
    chk("t6_new_mpr", mem_put_request, op(4'h0, 32'h80, 32'h0));
    cycle();
    c0_put_valid = 1'b0;
    #1;
    chkb("t6_new_c0gr", c0_get_ready, 1'b1);
    chk("t6_new_c0resp", c0_get_response, op(4'h0, 32'h80, 32'h0));
    chkb("t6_new_c1pr", c1_put_ready, 1'b1);
    cycle();
    c1_put_valid = 1'b0;
    #1;
    chkb("t6_new_c1gr", c1_get_ready, 1'b1);
    chk("t6_new_c1resp", c1_get_response, op(4'h0, 32'h90, 32'h0));
    cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
